// File: rtl/val2_imm_encoder_if.sv
// Request/result bundle for val2_imm_encoder.
//   in_valid / in_ready / value_in : request side (constant to encode)
//   out_valid / out_ready          : result side, result held until consumed
//   encodable                      : 1 when an immediate encoding exists
//   shifter_operand[11:0]          : {rotate_imm, immed_8}, zero when not encodable
//   checks_done[4:0]               : rotate candidates evaluated for the request
// The slave modport is the encoder; the master modport is its user.
interface val2_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value_in;
  logic        out_valid;
  logic        out_ready;
  logic        encodable;
  logic [11:0] shifter_operand;
  logic [4:0]  checks_done;

  modport master (
    output in_valid, value_in, out_ready,
    input  in_ready, out_valid, encodable, shifter_operand, checks_done
  );

  modport slave (
    input  in_valid, value_in, out_ready,
    output in_ready, out_valid, encodable, shifter_operand, checks_done
  );
endinterface

// File: rtl/val2_imm_encoder.sv
// Iterative encoder for the ARM data-processing immediate form.
// Searches rotate_imm = 0..15 for the lowest r with ROL(value, 2r)[31:8] == 0,
// testing CHECKS_PER_CYCLE candidates per clock, and reports
// {rotate_imm, immed_8} or that the constant cannot be encoded.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : val2_imm_encoder_if.slave (request/result handshake and outputs)
module val2_imm_encoder #(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  val2_imm_encoder_if.slave  bus
);

  localparam int C = CHECKS_PER_CYCLE;

  generate
    if (!(C == 1 || C == 2 || C == 4 || C == 8 || C == 16)) begin : g_bad_checks_per_cycle
      $error("val2_imm_encoder: CHECKS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [4:0]  rot_base_q, rot_base_d;
  logic [4:0]  checks_q, checks_d;
  logic        enc_q, enc_d;
  logic [11:0] so_q, so_d;

  // 32-bit rotate left via a doubled word so a zero shift needs no special case.
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] s);
    logic [63:0] t;
    t = {v, v} << s;
    return t[63:32];
  endfunction

  logic       hit;
  logic [3:0] hit_r;
  logic [7:0] hit_imm;
  logic       last_group;

  // Scan the group from the top down so the lowest passing r is written last.
  always_comb begin : p_group_search
    logic [4:0]  cand_r;
    logic [31:0] cand_v;
    hit     = 1'b0;
    hit_r   = '0;
    hit_imm = '0;
    cand_r  = '0;
    cand_v  = '0;
    for (int k = C - 1; k >= 0; k--) begin
      cand_r = rot_base_q + 5'(k);
      cand_v = rol32(value_q, {cand_r[3:0], 1'b0});
      if (cand_v[31:8] == 24'd0) begin
        hit     = 1'b1;
        hit_r   = cand_r[3:0];
        hit_imm = cand_v[7:0];
      end
    end
  end

  // The current group reaches candidate 15, so a miss here means unencodable.
  assign last_group = ({1'b0, rot_base_q} + 6'(C)) >= 6'd16;

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    rot_base_d = rot_base_q;
    checks_d   = checks_q;
    enc_d      = enc_q;
    so_d       = so_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          value_d    = bus.value_in;
          rot_base_d = '0;
          checks_d   = '0;
          state_d    = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          enc_d    = 1'b1;
          so_d     = {hit_r, hit_imm};
          checks_d = {1'b0, hit_r} + 5'd1;
          state_d  = DONE;
        end else if (last_group) begin
          enc_d    = 1'b0;
          so_d     = '0;
          checks_d = 5'd16;
          state_d  = DONE;
        end else begin
          checks_d   = checks_q + 5'(C);
          rot_base_d = rot_base_q + 5'(C);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      value_q    <= '0;
      rot_base_q <= '0;
      checks_q   <= '0;
      enc_q      <= 1'b0;
      so_q       <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      rot_base_q <= rot_base_d;
      checks_q   <= checks_d;
      enc_q      <= enc_d;
      so_q       <= so_d;
    end
  end

  assign bus.in_ready        = (state_q == IDLE);
  assign bus.out_valid       = (state_q == DONE);
  assign bus.encodable       = enc_q;
  assign bus.shifter_operand = so_q;
  assign bus.checks_done     = checks_q;

endmodule

// File: tb/tb_val2_imm_encoder.sv
// Directed bench for val2_imm_encoder with one instance at CHECKS_PER_CYCLE=1
// and one at CHECKS_PER_CYCLE=4; sel chooses which instance is exercised.
module tb_val2_imm_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  val2_imm_encoder_if if1 ();
  val2_imm_encoder_if if4 ();

  logic        sel  = 1'b0;
  logic        iv   = 1'b0;
  logic        ordy = 1'b1;
  logic [31:0] vin  = '0;

  assign if1.in_valid  = iv & ~sel;
  assign if4.in_valid  = iv & sel;
  assign if1.value_in  = vin;
  assign if4.value_in  = vin;
  assign if1.out_ready = ordy;
  assign if4.out_ready = ordy;

  wire        ov  = sel ? if4.out_valid       : if1.out_valid;
  wire        ir  = sel ? if4.in_ready        : if1.in_ready;
  wire        enc = sel ? if4.encodable       : if1.encodable;
  wire [11:0] so  = sel ? if4.shifter_operand : if1.shifter_operand;
  wire [4:0]  cd  = sel ? if4.checks_done     : if1.checks_done;

  val2_imm_encoder #(.CHECKS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  val2_imm_encoder #(.CHECKS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] s);
    logic [63:0] t;
    t = {v, v} >> s;
    return t[31:0];
  endfunction

  // Reference: try each r, take the low byte that would rotate back into place,
  // and accept it only if decoding it reproduces the value.
  task automatic model(input logic [31:0] v, input int cpc, output bit xenc,
                       output logic [11:0] xso, output logic [4:0] xcd, output int xedges);
    logic [7:0] imm;
    xenc = 1'b0; xso = '0; xcd = 5'd16; xedges = 16 / cpc;
    for (int r = 15; r >= 0; r--) begin
      imm = ror32(v, 5'(32 - 2 * r)) [7:0];
      if (ror32({24'd0, imm}, 5'(2 * r)) == v) begin
        xenc = 1'b1; xso = {4'(r), imm}; xcd = 5'(r + 1);
        xedges = (r + cpc) / cpc;
      end
    end
  endtask

  // Called at a negedge with out_ready=1. xedges = clock edges after the
  // accepting edge until out_valid is seen.
  task automatic run(input logic [31:0] v, input bit xenc, input logic [11:0] xso,
                     input logic [4:0] xcd, input int xedges, input string tag);
    int n;
    chk(32'(ir), 32'd1, {tag, ".in_ready"});
    vin = v; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    n = 0;
    while (ov !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk(32'(n), 32'(xedges), {tag, ".latency"});
    chk(32'(enc), 32'(xenc), {tag, ".encodable"});
    chk(32'(so), 32'(xso), {tag, ".shifter_operand"});
    chk(32'(cd), 32'(xcd), {tag, ".checks_done"});
    if (enc === 1'b1)
      chk(ror32({24'd0, so[7:0]}, {so[11:8], 1'b0}), v, {tag, ".roundtrip"});
    @(posedge clk);
    @(negedge clk);
    chk(32'(ov), 32'd0, {tag, ".out_valid_drop"});
    chk(32'(ir), 32'd1, {tag, ".in_ready_rise"});
  endtask

  initial begin
    bit          menc;
    logic [11:0] mso;
    logic [4:0]  mcd;
    int          medges;
    logic [31:0] rv;
    int          n;

    // Reset values
    @(negedge clk);
    chk(32'(if1.in_ready), 32'd1, "reset.in_ready");
    chk(32'(if1.out_valid), 32'd0, "reset.out_valid");
    chk(32'(if1.encodable), 32'd0, "reset.encodable");
    chk(32'(if1.shifter_operand), 32'd0, "reset.shifter_operand");
    chk(32'(if1.checks_done), 32'd0, "reset.checks_done");
    rst = 1'b0;
    @(negedge clk);

    // CHECKS_PER_CYCLE = 1 directed vectors
    sel = 1'b0;
    run(32'h000000FF, 1'b1, 12'h0FF, 5'd1, 1, "c1_ff");
    run(32'h00000000, 1'b1, 12'h000, 5'd1, 1, "c1_zero");
    run(32'hFF000000, 1'b1, 12'h4FF, 5'd5, 5, "c1_ff000000");
    run(32'hF000000F, 1'b1, 12'h2FF, 5'd3, 3, "c1_f000000f");
    run(32'h00000104, 1'b1, 12'hF41, 5'd16, 16, "c1_104");
    run(32'h00000102, 1'b0, 12'h000, 5'd16, 16, "c1_102");
    run(32'h12345678, 1'b0, 12'h000, 5'd16, 16, "c1_12345678");

    // CHECKS_PER_CYCLE = 4 directed vectors
    sel = 1'b1;
    run(32'h12345678, 1'b0, 12'h000, 5'd16, 4, "c4_12345678");
    run(32'h000000FF, 1'b1, 12'h0FF, 5'd1, 1, "c4_ff");
    run(32'hFF000000, 1'b1, 12'h4FF, 5'd5, 2, "c4_ff000000");
    run(32'h00000104, 1'b1, 12'hF41, 5'd16, 4, "c4_104");
    sel = 1'b0;

    // Backpressure: result held, busy input ignored
    ordy = 1'b0;
    vin = 32'hFF000000; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    n = 0;
    while (ov !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk(32'(n), 32'd5, "bp.latency");
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin vin = 32'h12345678; iv = 1'b1; end
      if (i == 5) iv = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk(32'(ov), 32'd1, "bp.out_valid");
      chk(32'(ir), 32'd0, "bp.in_ready");
      chk(32'(enc), 32'd1, "bp.encodable");
      chk(32'(so), 32'h4FF, "bp.shifter_operand");
      chk(32'(cd), 32'd5, "bp.checks_done");
    end
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(32'(ov), 32'd0, "bp.release_out_valid");
    chk(32'(ir), 32'd1, "bp.release_in_ready");
    run(32'hF000000F, 1'b1, 12'h2FF, 5'd3, 3, "bp_next");

    // Asynchronous reset in the middle of an unencodable search
    vin = 32'h00000102; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk(32'(if1.in_ready), 32'd1, "midrst.in_ready");
    chk(32'(if1.out_valid), 32'd0, "midrst.out_valid");
    chk(32'(if1.encodable), 32'd0, "midrst.encodable");
    chk(32'(if1.shifter_operand), 32'd0, "midrst.shifter_operand");
    chk(32'(if1.checks_done), 32'd0, "midrst.checks_done");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk(32'(if1.in_ready), 32'd1, "postrst.in_ready");
    run(32'h000003FC, 1'b1, 12'hFFF, 5'd16, 16, "postrst_3fc");

    // Random regression against the decode-based reference
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 150; i++) begin
        if (i[0]) rv = ror32({24'd0, 8'($urandom)}, 5'(2 * $urandom_range(0, 15)));
        else      rv = $urandom;
        model(rv, s ? 4 : 1, menc, mso, mcd, medges);
        run(rv, menc, mso, mcd, medges, s ? "rand_c4" : "rand_c1");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
